waveform_fetch: RTL

//  Address sequencer and sample buffer that sits directly in front of waveform_rom.
//  On a start pulse it walks ROM addresses base, base+step, ... and drives them onto rom_addr.
//  It absorbs the ROM's registered read latency and queues the returned words in a small FIFO.

---
 rtl/waveform_fetch.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/waveform_fetch.sv
// waveform_fetch: address sequencer and sample buffer placed in front of waveform_rom.
// On a start pulse it issues ROM addresses base, base+step, ... (modulo 2**AW).
// Issues are tagged through a shift register that matches the ROM's read latency.
// Returned words are queued in a small FIFO and leave on a valid/ready stream.
// Loop mode replays the table without a bubble.
//
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   start           - begin a sequence (sampled only in IDLE)
//   base_addr       - first ROM address, latched on start
//   length          - samples per pass, latched on start (0 means 2**AW)
//   step            - address increment, latched on start
//   loop            - sampled at the last issue of a pass; 1 replays from base
//   abort           - terminate immediately: flush the FIFO, drop in-flight returns
//   rom_addr        - address to waveform_rom
//   rom_data        - ROM word, valid ROM_LAT cycles after its address
//   sample          - FIFO head
//   sample_valid    - FIFO non-empty
//   sample_ready    - downstream accept
//   busy            - high in FETCH or DRAIN
//   done            - one-cycle pulse on normal completion
module waveform_fetch #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 8,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] length,
    input  logic [AW-1:0] step,
    input  logic          loop,
    input  logic          abort,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] sample,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          busy,
    output logic          done
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW = $clog2(ROM_LAT + 2);
    localparam int unsigned SW = CW + IW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   last_q, last_d;
    logic [AW-1:0]   step_q, step_d;
    logic [AW-1:0]   k_q, k_d;
    logic [AW-1:0]   next_addr_q, next_addr_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0] tag_q, tag_d;
    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [DW-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   sample_q, sample_d;
    logic            sample_valid_q, sample_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [IW-1:0]   inflight;
    logic            credit_ok;
    logic            issue;
    logic            push;
    logic            pop;

    assign rom_addr     = rom_addr_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // Outstanding issues: tag_q[0] lines up with rom_addr, tag_q[ROM_LAT] with rom_data.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= int'(ROM_LAT); i++) begin
            inflight = inflight + IW'(tag_q[i]);
        end
    end

    // Issue only when every outstanding request is guaranteed a FIFO slot.
    assign credit_ok = (SW'(count_q) + SW'(inflight)) < SW'(FIFO_DEPTH);
    assign push      = tag_q[ROM_LAT];
    assign pop       = sample_valid_q & sample_ready;

    // Sequencer: next state, issue decision and address walk.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        last_d      = last_q;
        step_d      = step_q;
        k_d         = k_q;
        next_addr_d = next_addr_q;
        rom_addr_d  = rom_addr_q;
        issue       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    base_d      = base_addr;
                    last_d      = length - AW'(1);   // length 0 wraps to the full table
                    step_d      = step;
                    k_d         = '0;
                    next_addr_d = base_addr;
                end
            end
            S_FETCH: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    rom_addr_d = next_addr_q;
                    if (k_q == last_q) begin
                        k_d         = '0;
                        next_addr_d = base_q;
                        if (!loop) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        k_d         = k_q + AW'(1);
                        next_addr_d = next_addr_q + step_q;
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight == '0) && (count_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides every transition, including a pending DONE
        if (abort) begin
            state_d    = S_IDLE;
            issue      = 1'b0;
            rom_addr_d = rom_addr_q;
        end

        busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Return path and output FIFO.
    always_comb begin
        tag_d          = {tag_q[ROM_LAT-1:0], issue};
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        sample_d       = sample_q;
        sample_valid_d = sample_valid_q;

        if (push) begin
            mem_d[wr_ptr_q] = rom_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Head register follows the FIFO read side; a push into an empty FIFO bypasses memory.
        if (pop) begin
            if (count_q > CW'(1)) begin
                sample_d = mem_q[rd_ptr_q + PW'(1)];
            end else if (push) begin
                sample_d = rom_data;
            end
        end else if (push && (count_q == '0)) begin
            sample_d = rom_data;
        end

        if (abort) begin
            tag_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        sample_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            last_q         <= '0;
            step_q         <= '0;
            k_q            <= '0;
            next_addr_q    <= '0;
            rom_addr_q     <= '0;
            tag_q          <= '0;
            mem_q          <= '{default: '0};
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            last_q         <= last_d;
            step_q         <= step_d;
            k_q            <= k_d;
            next_addr_q    <= next_addr_d;
            rom_addr_q     <= rom_addr_d;
            tag_q          <= tag_d;
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

endmodule
